// File: rtl/tri_bus_arbiter.sv
// rtl/tri_bus_arbiter.sv - round-robin arbiter that owns a shared tri-state result bus
module tri_bus_arbiter #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int HOLD  = 1,
    parameter int TURN  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NSRC-1:0]       req,
    input  logic [NSRC*WIDTH-1:0] data_in,
    output tri   [WIDTH-1:0]      bus,
    output logic                  bus_valid,
    output logic [NSRC-1:0]       grant,
    output logic [NSRC-1:0]       ack
);

    localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD - 1);
    localparam logic [1:0] TURN_LOAD = (TURN > 0) ? 2'(TURN - 1) : 2'd0;
    localparam logic [PW-1:0] LAST_SRC = PW'(NSRC - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        TURNAROUND
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     owner;
    logic [NSRC-1:0]   grant_reg;
    logic [WIDTH-1:0]  data_reg;
    logic [3:0]        hold_cnt;
    logic [1:0]        turn_cnt;

    logic [WIDTH-1:0]  words [NSRC];
    logic              sel_found;
    logic [PW-1:0]     sel;
    logic [NSRC-1:0]   sel_onehot;
    logic [WIDTH-1:0]  sel_data;
    logic [PW-1:0]     idx_p;

    // First pending source scanning upward from rr_ptr, wrapping explicitly so
    // non-power-of-2 NSRC never selects a nonexistent source.
    always_comb begin
        int idx;
        idx        = 0;
        idx_p      = '0;
        sel_found  = 1'b0;
        sel        = '0;
        sel_onehot = '0;
        sel_data   = '0;
        for (int i = 0; i < NSRC; i++) begin
            words[i] = data_in[i*WIDTH +: WIDTH];
        end
        for (int k = 0; k < NSRC; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NSRC) begin
                idx = idx - NSRC;
            end
            idx_p = PW'(idx);
            if (!sel_found && req[idx_p]) begin
                sel_found         = 1'b1;
                sel               = idx_p;
                sel_onehot        = '0;
                sel_onehot[idx_p] = 1'b1;
                sel_data          = words[idx_p];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (hold_cnt == 4'd0) begin
                    state_nxt = (TURN > 0) ? TURNAROUND : IDLE;
                end
            end
            TURNAROUND: begin
                if (turn_cnt == 2'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            owner     <= '0;
            grant_reg <= '0;
            data_reg  <= '0;
            hold_cnt  <= '0;
            turn_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        owner     <= sel;
                        grant_reg <= sel_onehot;
                        data_reg  <= sel_data;
                        hold_cnt  <= HOLD_LOAD;
                    end
                end
                DRIVE: begin
                    if (hold_cnt == 4'd0) begin
                        rr_ptr    <= (owner == LAST_SRC) ? '0 : owner + 1'b1;
                        grant_reg <= '0;
                        turn_cnt  <= TURN_LOAD;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                TURNAROUND: begin
                    if (turn_cnt != 2'd0) begin
                        turn_cnt <= turn_cnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from state so an asynchronous reset releases the bus at once.
    assign bus_valid = (state == DRIVE);
    assign grant     = bus_valid ? grant_reg : '0;
    assign ack       = (bus_valid && hold_cnt == 4'd0) ? grant_reg : '0;
    assign bus       = bus_valid ? data_reg : {WIDTH{1'bz}};

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// tb/tb_tri_bus_arbiter.sv - directed self-checking bench for tri_bus_arbiter
module tb_tri_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Default configuration
    logic [3:0]   req_d = '0;
    logic [127:0] din_d = '0;
    wire  [31:0]  bus_d;
    logic         valid_d;
    logic [3:0]   grant_d, ack_d;

    // NSRC = 3
    logic [2:0]   req_n = '0;
    logic [95:0]  din_n = '0;
    wire  [31:0]  bus_n;
    logic         valid_n;
    logic [2:0]   grant_n, ack_n;

    // HOLD = 3, TURN = 0
    logic [3:0]   req_h = '0;
    logic [127:0] din_h = '0;
    wire  [31:0]  bus_h;
    logic         valid_h;
    logic [3:0]   grant_h, ack_h;

    // HOLD = 2, TURN = 1
    logic [3:0]   req_t = '0;
    logic [127:0] din_t = '0;
    wire  [31:0]  bus_t;
    logic         valid_t;
    logic [3:0]   grant_t, ack_t;

    tri_bus_arbiter #(.WIDTH(32), .NSRC(4), .HOLD(1), .TURN(1)) u_def (
        .clk(clk), .rst(rst), .req(req_d), .data_in(din_d),
        .bus(bus_d), .bus_valid(valid_d), .grant(grant_d), .ack(ack_d));

    tri_bus_arbiter #(.WIDTH(32), .NSRC(3), .HOLD(1), .TURN(1)) u_n3 (
        .clk(clk), .rst(rst), .req(req_n), .data_in(din_n),
        .bus(bus_n), .bus_valid(valid_n), .grant(grant_n), .ack(ack_n));

    tri_bus_arbiter #(.WIDTH(32), .NSRC(4), .HOLD(3), .TURN(0)) u_h3 (
        .clk(clk), .rst(rst), .req(req_h), .data_in(din_h),
        .bus(bus_h), .bus_valid(valid_h), .grant(grant_h), .ack(ack_h));

    tri_bus_arbiter #(.WIDTH(32), .NSRC(4), .HOLD(2), .TURN(1)) u_h2 (
        .clk(clk), .rst(rst), .req(req_t), .data_in(din_t),
        .bus(bus_t), .bus_valid(valid_t), .grant(grant_t), .ack(ack_t));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // A released bus reads as Z (or a resolved default), never as the last word.
    task automatic chk_float(input string tag, input logic [31:0] obs, input logic [31:0] last);
        checks++;
        assert (obs !== last) else begin
            errors++;
            $error("FAIL %s observed=%h expected=released (not %h)", tag, obs, last);
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_valid", 32'(valid_d), 32'd0);
        chk("rst_grant", 32'(grant_d), 32'd0);
        chk("rst_ack",   32'(ack_d),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single request from source 2
        req_d = 4'b0100;
        din_d[2*32 +: 32] = 32'h1234_5678;
        tick();
        chk("single_grant", 32'(grant_d), 32'h4);
        chk("single_bus",   bus_d,        32'h1234_5678);
        chk("single_valid", 32'(valid_d), 32'd1);
        chk("single_ack",   32'(ack_d),   32'h4);
        req_d = 4'b0000;
        tick();
        chk("single_turn_valid", 32'(valid_d), 32'd0);
        chk("single_turn_ack",   32'(ack_d),   32'd0);
        chk_float("single_turn_bus", bus_d, 32'h1234_5678);
        tick();
        chk("single_idle_valid", 32'(valid_d), 32'd0);
        chk("single_idle_grant", 32'(grant_d), 32'd0);

        // Asynchronous reset in the middle of a transfer
        req_d = 4'b0010;
        din_d[1*32 +: 32] = 32'hDEAD_BEEF;
        tick();
        chk("pre_rst_bus", bus_d, 32'hDEAD_BEEF);
        req_d = 4'b0000;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(valid_d), 32'd0);
        chk("async_rst_grant", 32'(grant_d), 32'd0);
        chk("async_rst_ack",   32'(ack_d),   32'd0);
        chk_float("async_rst_bus", bus_d, 32'hDEAD_BEEF);
        #1 rst = 1'b0;
        tick();
        chk("post_rst_valid", 32'(valid_d), 32'd0);
        tick();
        chk("post_rst_grant", 32'(grant_d), 32'd0);
        chk_float("post_rst_bus", bus_d, 32'hDEAD_BEEF);

        // Round robin with all sources requesting; rr_ptr restarts at 0
        for (int i = 0; i < 4; i++) din_d[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
        req_d = 4'b1111;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk($sformatf("rr_grant%0d", n), 32'(grant_d), 32'(4'b0001 << n));
            chk($sformatf("rr_bus%0d", n),   bus_d,        32'hC0DE_0000 + 32'(n));
            chk($sformatf("rr_ack%0d", n),   32'(ack_d),   32'(4'b0001 << n));
            if (n == 3) req_d = 4'b1001;
            tick();
            chk($sformatf("rr_turn_grant%0d", n), 32'(grant_d), 32'd0);
            tick();
            chk($sformatf("rr_idle_valid%0d", n), 32'(valid_d), 32'd0);
        end
        tick();
        chk("rr_after3_grant", 32'(grant_d), 32'h1);
        tick();
        tick();
        tick();
        chk("rr_after0_grant", 32'(grant_d), 32'h8);
        req_d = 4'b0000;
        tick();
        tick();

        // NSRC = 3 wrap: 0, 1, then back to 0 past idle source 2
        req_n = 3'b011;
        tick();
        chk("n3_grant_a", 32'(grant_n), 32'h1);
        tick(); tick(); tick();
        chk("n3_grant_b", 32'(grant_n), 32'h2);
        tick(); tick(); tick();
        chk("n3_grant_wrap", 32'(grant_n), 32'h1);
        req_n = 3'b000;
        tick();

        // HOLD = 3, TURN = 0
        req_h = 4'b0010;
        din_h[1*32 +: 32] = 32'hA5A5_A5A5;
        tick();
        req_h = 4'b0000;
        chk("h3_valid1", 32'(valid_h), 32'd1);
        chk("h3_ack1",   32'(ack_h),   32'd0);
        tick();
        chk("h3_valid2", 32'(valid_h), 32'd1);
        chk("h3_ack2",   32'(ack_h),   32'd0);
        tick();
        chk("h3_valid3", 32'(valid_h), 32'd1);
        chk("h3_ack3",   32'(ack_h),   32'h2);
        chk("h3_bus3",   bus_h,        32'hA5A5_A5A5);
        tick();
        chk("h3_idle_valid", 32'(valid_h), 32'd0);
        chk("h3_idle_grant", 32'(grant_h), 32'd0);

        // HOLD = 2: data captured at grant, req drop ignored
        req_t = 4'b0001;
        din_t[0 +: 32] = 32'h1;
        tick();
        chk("stab_bus1", bus_t,        32'h1);
        chk("stab_ack1", 32'(ack_t),   32'd0);
        din_t[0 +: 32] = 32'h2;
        req_t = 4'b0000;
        tick();
        chk("stab_bus2", bus_t,        32'h1);
        chk("stab_ack2", 32'(ack_t),   32'h1);
        tick();
        chk("stab_turn_valid", 32'(valid_t), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
